mult_control: RTL
=================

Name: mult_control

Overview:
Sequencing controller for the nibble-serial 8x8 multiplier datapath. The datapath has one 4x4 multiplier, a nibble-shift unit (shift_cntrl n gives a left shift of 4*n) and a 16-bit accumulator. This block steps the datapath through the four partial products a_lo*b_lo, a_hi*b_lo, a_lo*b_hi and a_hi*b_hi. For each partial product it drives the operand nibble selects, the shift code and the accumulator controls, and it reports busy/done to the host.

Parameters:
- HOLD_DONE, 1, 1: done stays high in DONE until start is low. 0: done is a one-cycle pulse, then the FSM returns to IDLE.
- START_EDGE, 1, 1: a multiply launches only on a start rising edge (start=1 and start_q=0). 0: start level high in IDLE launches.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- reset_a  input  1  asynchronous, active-low reset
- start  input  1  multiply request from the host
- a_sel  output  1  operand A nibble select (0=A[3:0], 1=A[7:4])
- b_sel  output  1  operand B nibble select (0=B[3:0], 1=B[7:4])
- shift_cntrl  output  3  shift code to the shift unit (000=x1, 001=<<4, 010=<<8)
- accum_en  output  1  accumulator captures this cycle
- accum_load  output  1  when set with accum_en, the accumulator loads the shifted product instead of adding it
- busy  output  1  high in LSB, MID and MSB
- done  output  1  result valid in the accumulator
- state_out  output  3  current state encoding, for debug/7-seg display

Behaviour:
- Registers: state[2:0], cnt (1 bit, MID sub-step), start_q (start delayed one cycle).
- All outputs are decoded combinationally from state and cnt only. There is no combinational path from start to any output.
- State encodings: IDLE=000, LSB=001, MID=010, MSB=011, DONE=100.
- Reset (reset_a=0, asynchronous):
  - state=IDLE, cnt=0, start_q=0, immediately.
  - Outputs: a_sel=0, b_sel=0, shift_cntrl=000, accum_en=0, accum_load=0, busy=0, done=0, state_out=000.
- Reset asserted mid-operation aborts the multiply. No done is produced, and the accumulator contents are don't-care.
- IDLE:
  - Outputs are at their reset values.
  - Launch condition: rising edge of start (START_EDGE=1) or start=1 (START_EDGE=0).
  - On launch: next state LSB, cnt<=0.
- LSB:
  - a_sel=0, b_sel=0, shift_cntrl=000, accum_en=1, accum_load=1, busy=1.
  - Next state MID, cnt<=0.
- MID, two cycles:
  - Common outputs: shift_cntrl=001, accum_en=1, accum_load=0, busy=1.
  - cnt=0: a_sel=1, b_sel=0; cnt<=1, stay in MID.
  - cnt=1: a_sel=0, b_sel=1; next state MSB, cnt<=0.
- MSB:
  - a_sel=1, b_sel=1, shift_cntrl=010, accum_en=1, accum_load=0, busy=1.
  - Next state DONE.
- DONE:
  - done=1, busy=0, accum_en=0.
  - HOLD_DONE=1: stay while start=1; go to IDLE on the first cycle start=0.
  - HOLD_DONE=0: go to IDLE after one cycle regardless of start.
- Latency and throughput:
  - Launch sampled at edge 0 gives LSB at edge 1, MID at edges 2-3, MSB at edge 4 and DONE at edge 5.
  - done is visible 5 cycles after the launch edge.
  - Exactly 4 accum_en cycles per multiply.
- start while busy or in DONE is ignored; no re-launch and no queueing.
- START_EDGE=1: start_q updates every cycle in all states. Therefore a start held high through DONE does not re-launch on returning to IDLE.
- START_EDGE=0 with HOLD_DONE=0 and start held high: back-to-back multiplies, with one IDLE cycle between DONE and the next LSB.
- Illegal states (101, 110, 111):
  - Outputs: shift_cntrl=111, accum_en=0, busy=0, done=0.
  - Next state IDLE, cnt<=0.
- No arithmetic is done in this block. The accumulator width (16) and the shift range are owned by the datapath.

Test Plan:
- Reset and idle: reset_a low for 3 cycles with start toggling -> all outputs 0, state_out=000 throughout; release with start=0 -> state stays IDLE.
- Basic sequence (defaults), start rises at edge 0 and is held:
  - (a_sel,b_sel,shift_cntrl,accum_load) = (0,0,000,1), (1,0,001,0), (0,1,001,0), (1,1,010,0) on cycles 1-4.
  - done=1 from cycle 5 while start=1; IDLE one cycle after start drops.
- Integrated 8x8 check with the datapath model, A=8'hFF, B=8'hFF -> accumulator=16'hFE01 when done=1. Also cover A=8'h00,B=8'h5A -> 0, and A=8'h12,B=8'h34 -> 16'h03A8.
- Start during busy: extra start pulses in cycles 2 and 4 -> same 4-cycle sequence, exactly one done, no second launch.
- Reset mid-op: reset_a low during MID cnt=1 -> outputs zero asynchronously (same cycle). After release, state is IDLE and no done is seen until a new start edge.
- HOLD_DONE=0, START_EDGE=0, start held high -> done pulses every 6 cycles (1 IDLE + 4 busy + 1 DONE). Force an illegal state 111 -> shift_cntrl=111, IDLE on the next cycle.

Source files
------------

// File: rtl/mult_control.sv
// -----------------------------------------------------------------------------
// mult_control
//
// Sequencing controller for a nibble-serial 8x8 multiplier. The datapath has
// one 4x4 multiplier, a nibble-shift unit and a 16-bit accumulator. This block
// walks the datapath through the four partial products
//   a_lo*b_lo (<<0, load), a_hi*b_lo (<<4), a_lo*b_hi (<<4), a_hi*b_hi (<<8)
// and reports busy/done to the host.
//
// Parameters
//   HOLD_DONE  1: done held in DONE until start goes low; 0: one-cycle done
//   START_EDGE 1: launch on start rising edge;   0: launch on start level
//
// Ports
//   clk          system clock, rising edge
//   reset_a      asynchronous active-low reset
//   start        multiply request from the host
//   a_sel        operand A nibble select (0 = A[3:0], 1 = A[7:4])
//   b_sel        operand B nibble select (0 = B[3:0], 1 = B[7:4])
//   shift_cntrl  shift code (000 = x1, 001 = <<4, 010 = <<8, 111 = illegal state)
//   accum_en     accumulator captures this cycle
//   accum_load   with accum_en: load the shifted product instead of adding it
//   busy         high in LSB, MID and MSB
//   done         result valid in the accumulator
//   state_out    current state encoding for debug display
// -----------------------------------------------------------------------------
module mult_control #(
    parameter bit HOLD_DONE  = 1'b1,
    parameter bit START_EDGE = 1'b1
) (
    input  logic       clk,
    input  logic       reset_a,
    input  logic       start,
    output logic       a_sel,
    output logic       b_sel,
    output logic [2:0] shift_cntrl,
    output logic       accum_en,
    output logic       accum_load,
    output logic       busy,
    output logic       done,
    output logic [2:0] state_out
);

    typedef enum logic [2:0] {
        IDLE = 3'b000,
        LSB  = 3'b001,
        MID  = 3'b010,
        MSB  = 3'b011,
        DONE = 3'b100
    } state_e;

    // The state register is kept as a plain 3-bit vector so that the three
    // unused encodings are representable and recover through the default arm.
    logic [2:0] state;
    logic       cnt;      // MID sub-step: 0 = a_hi*b_lo, 1 = a_lo*b_hi
    logic       start_q;  // start delayed one cycle, for edge detection
    logic       launch;

    // Launch only affects the next state; outputs never see start directly.
    assign launch = START_EDGE ? (start & ~start_q) : start;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            state   <= IDLE;
            cnt     <= 1'b0;
            start_q <= 1'b0;
        end else begin
            // Tracked in every state so a start held through DONE is not seen
            // as a fresh edge when the FSM returns to IDLE.
            start_q <= start;
            case (state)
                IDLE: begin
                    if (launch) begin
                        state <= LSB;
                        cnt   <= 1'b0;
                    end
                end
                LSB: begin
                    state <= MID;
                    cnt   <= 1'b0;
                end
                MID: begin
                    if (!cnt) begin
                        cnt <= 1'b1;
                    end else begin
                        state <= MSB;
                        cnt   <= 1'b0;
                    end
                end
                MSB: begin
                    state <= DONE;
                end
                DONE: begin
                    if (!HOLD_DONE || !start) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 1'b0;
                end
            endcase
        end
    end

    // Output decode from state and cnt only.
    // NOTE: every output gets a default before the case so no path through
    // the block leaves a signal unassigned, which would infer a latch.
    always_comb begin
        a_sel       = 1'b0;
        b_sel       = 1'b0;
        shift_cntrl = 3'b000;
        accum_en    = 1'b0;
        accum_load  = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
            end
            LSB: begin
                accum_en   = 1'b1;
                accum_load = 1'b1;
                busy       = 1'b1;
            end
            MID: begin
                a_sel       = ~cnt;
                b_sel       = cnt;
                shift_cntrl = 3'b001;
                accum_en    = 1'b1;
                busy        = 1'b1;
            end
            MSB: begin
                a_sel       = 1'b1;
                b_sel       = 1'b1;
                shift_cntrl = 3'b010;
                accum_en    = 1'b1;
                busy        = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                // Illegal encoding: flag it on the shift code, keep the
                // accumulator and host handshake quiet.
                shift_cntrl = 3'b111;
            end
        endcase
    end

    assign state_out = state;

endmodule
